// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, byte-enable presets and the address error check.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;

  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

  // Misaligned, or word index past the end of the array; addresses never wrap.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return ((addr[1:0] & ADDR_ALIGN_MASK) != 2'b00) || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core (master) and the data memory (slave).
// Handshake: a beat transfers at a rising edge where valid & ready are both 1;
// the initiator holds a request stable while valid is high, and the responder
// holds rsp_rdata/rsp_err stable while rsp_valid is high.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage: synchronous byte-lane write, combinational read.
// Contents are deliberately not reset.
module dmem_bank #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// byte-lane writes and an error response for misaligned / out-of-range addresses.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus,
  output state_e           state_o
);

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bank_we;
  logic [31:0] bank_rdata;

  dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .idx_i   (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    bank_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = addr_err(addr_q, DEPTH);
          rdata_d = '0;
          // Errors never touch the array; writes report zero data.
          if (!err_d) begin
            if (we_q) bank_we = 1'b1;
            else      rdata_d = bank_rdata;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance for most
// scenarios and a LATENCY=0 instance for back-to-back timing.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  state_e st2, st0;

  dmem_responder_if if2();
  dmem_responder_if if0();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .bus(if2.slave), .state_o(st2));
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(if0.slave), .state_o(st0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word storage keyed by word index, only written words exist.
  logic [31:0] ref_mem [int unsigned];
  logic [32:0] exp_q [$];

  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [32:0] exp, output bit known);
    logic [31:0] w;
    int unsigned idx;
    known = 1'b1;
    idx = addr / 4;
    if ((addr % 4) != 0 || addr >= 32'(DEPTH * 4)) begin
      exp = {1'b1, 32'h0};
    end else if (we) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = w;
      exp = {1'b0, 32'h0};
    end else begin
      known = ref_mem.exists(idx);
      exp = {1'b0, known ? ref_mem[idx] : 32'h0};
    end
  endtask

  function automatic logic f_req_ready(input bit sel);
    return sel ? if0.req_ready : if2.req_ready;
  endfunction
  function automatic logic f_rsp_valid(input bit sel);
    return sel ? if0.rsp_valid : if2.rsp_valid;
  endfunction
  function automatic logic [31:0] f_rsp_rdata(input bit sel);
    return sel ? if0.rsp_rdata : if2.rsp_rdata;
  endfunction
  function automatic logic f_rsp_err(input bit sel);
    return sel ? if0.rsp_err : if2.rsp_err;
  endfunction

  task automatic drive_req(input bit sel, input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin
      if0.req_valid = v; if0.req_we = we; if0.req_addr = a; if0.req_wdata = wd; if0.req_be = be;
    end else begin
      if2.req_valid = v; if2.req_we = we; if2.req_addr = a; if2.req_wdata = wd; if2.req_be = be;
    end
  endtask

  task automatic set_rsp_ready(input bit sel, input logic r);
    if (sel) if0.rsp_ready = r; else if2.rsp_ready = r;
  endtask

  // One transaction; dly<0 leaves rsp_ready low on return for the caller to finish.
  task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int dly,
                        output logic [31:0] rdata, output logic err,
                        output int acc, output int rsp);
    int n;
    @(negedge clk);
    set_rsp_ready(sel, dly == 0);
    drive_req(sel, 1'b1, we, addr, wdata, be);
    n = 0;
    while (!f_req_ready(sel) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout sel=%0d addr=%h", sel, addr);
    end
    acc = cyc + 1;
    @(negedge clk);
    drive_req(sel, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
    n = 0;
    while (!f_rsp_valid(sel) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL rsp_timeout sel=%0d addr=%h", sel, addr);
    end
    rsp = cyc;
    rdata = f_rsp_rdata(sel);
    err = f_rsp_err(sel);
    if (dly > 0) begin
      repeat (dly) @(negedge clk);
      set_rsp_ready(sel, 1'b1);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0 || if2.rsp_rdata !== 32'h0 ||
        if2.rsp_err !== 1'b0 || st2 !== IDLE) begin
      failures++;
      $display("FAIL reset_l2 got rdy=%b vld=%b rd=%h err=%b st=%0d want 1 0 0 0 IDLE",
               if2.req_ready, if2.rsp_valid, if2.rsp_rdata, if2.rsp_err, st2);
    end
    checks++;
    if (if0.req_ready !== 1'b1 || if0.rsp_valid !== 1'b0 || st0 !== IDLE) begin
      failures++;
      $display("FAIL reset_l0 got rdy=%b vld=%b st=%0d want 1 0 IDLE",
               if0.req_ready, if0.rsp_valid, st0);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp; bit known;
    model(1'b1, 32'h40, 32'h0BADF00D, BE_WORD, exp, known);
    do_req(1'b0, 1'b1, 32'h40, 32'h0BADF00D, BE_WORD, 0, rd, er, a, r);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, BE_WORD);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++;
    if (if2.req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_pre_wait got req_ready=%b want 0", if2.req_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0 || if2.rsp_rdata !== 32'h0 ||
        if2.rsp_err !== 1'b0 || st2 !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_wait got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
               if2.req_ready, if2.rsp_valid, if2.rsp_rdata, if2.rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(1'b0, 32'h40, 32'h0, 4'h0, exp, known);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL rst_dropped_write got %h want %h", {er, rd}, exp);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp; bit known;
    model(1'b1, 32'h64, 32'h19, BE_WORD, exp, known);
    do_req(1'b0, 1'b1, 32'h64, 32'h19, BE_WORD, 0, rd, er, a, r);
    checks++;
    if (r - a !== 3) begin
      failures++; $display("FAIL lat2_timing got %0d want 3", r - a);
    end
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL lat2_write_rsp got %h want %h", {er, rd}, exp);
    end
    model(1'b0, 32'h64, 32'h0, 4'h0, exp, known);
    do_req(1'b0, 1'b0, 32'h64, 32'h0, 4'h0, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL lat2_readback got %h want %h", {er, rd}, exp);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp; bit known;
    model(1'b1, 32'h10, 32'h11223344, BE_WORD, exp, known);
    do_req(1'b0, 1'b1, 32'h10, 32'h11223344, BE_WORD, 0, rd, er, a, r);
    model(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, exp, known);
    do_req(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 1, rd, er, a, r);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== {1'b0, 32'h11BB33DD}) begin
      failures++; $display("FAIL byte_lanes got %h want %h", {er, rd}, {1'b0, 32'h11BB33DD});
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp; bit known;
    model(1'b0, 32'h400, 32'h0, 4'h0, exp, known);
    do_req(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL err_range got %h want %h", {er, rd}, exp);
    end
    model(1'b1, 32'h66, 32'hFFFFFFFF, BE_WORD, exp, known);
    do_req(1'b0, 1'b1, 32'h66, 32'hFFFFFFFF, BE_WORD, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL err_misalign got %h want %h", {er, rd}, exp);
    end
    model(1'b0, 32'h64, 32'h0, 4'h0, exp, known);
    do_req(1'b0, 1'b0, 32'h64, 32'h0, 4'h0, 0, rd, er, a, r);
    checks++;
    if ({er, rd} !== exp) begin
      failures++; $display("FAIL err_no_modify got %h want %h", {er, rd}, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp; bit known;
    logic [31:0] addrs [3];
    addrs[0] = 32'h64; addrs[1] = 32'h10; addrs[2] = 32'h40;
    model(1'b0, 32'h64, 32'h0, 4'h0, exp, known);
    do_req(1'b0, 1'b0, 32'h64, 32'h0, 4'h0, -1, rd, er, a, r);
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b0, 1'b1, 1'b1, addrs[i % 3], $urandom, BE_WORD);
      @(negedge clk);
      checks++;
      if (if2.rsp_valid !== 1'b1 || {if2.rsp_err, if2.rsp_rdata} !== exp || if2.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got vld=%b rsp=%h rdy=%b want 1 %h 0",
                 i, if2.rsp_valid, {if2.rsp_err, if2.rsp_rdata}, if2.req_ready, exp);
      end
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp_ready(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0 || if2.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL bp_release got rdy=%b vld=%b rd=%h want 1 0 0",
               if2.req_ready, if2.rsp_valid, if2.rsp_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      model(1'b0, addrs[i], 32'h0, 4'h0, exp, known);
      do_req(1'b0, 1'b0, addrs[i], 32'h0, 4'h0, 0, rd, er, a, r);
      checks++;
      if ({er, rd} !== exp) begin
        failures++; $display("FAIL bp_no_access addr=%h got %h want %h", addrs[i], {er, rd}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int a, r; logic [32:0] exp, got; bit known;
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wd; int sel_kind;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, 32'h100 + 32'(4 * i), wd, BE_WORD, exp, known);
      do_req(1'b0, 1'b1, 32'h100 + 32'(4 * i), wd, BE_WORD, 0, rd, er, a, r);
    end
    for (int i = 0; i < 40; i++) begin
      sel_kind = $urandom_range(0, 9);
      addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if (sel_kind == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (sel_kind == 1) addr = (i % 2) ? 32'hFFFFFFFC : 32'h400 + 32'(4 * $urandom_range(0, 63));
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      model(we, addr, wd, be, exp, known);
      exp_q.push_back(exp);
      do_req(1'b0, we, addr, wd, be, $urandom_range(0, 3), rd, er, a, r);
      got = {er, rd};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || r - a !== 3) begin
        failures++;
        $display("FAIL rand%0d addr=%h we=%b be=%b got %h lat=%0d want %h lat=3",
                 i, addr, we, be, got, r - a, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int a0, r0, a1, r1; logic [32:0] exp0, exp1; bit known;
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    model(1'b1, 32'h0, w0, BE_WORD, exp0, known);
    do_req(1'b1, 1'b1, 32'h0, w0, BE_WORD, 0, rd, er, a0, r0);
    model(1'b1, 32'h4, w1, BE_WORD, exp0, known);
    do_req(1'b1, 1'b1, 32'h4, w1, BE_WORD, 0, rd, er, a0, r0);
    model(1'b0, 32'h0, 32'h0, 4'h0, exp0, known);
    model(1'b0, 32'h4, 32'h0, 4'h0, exp1, known);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, a0, r0);
    checks++;
    if ({er, rd} !== exp0 || r0 - a0 !== 1) begin
      failures++; $display("FAIL b2b_rd0 got %h lat=%0d want %h lat=1", {er, rd}, r0 - a0, exp0);
    end
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, a1, r1);
    checks++;
    if ({er, rd} !== exp1 || r1 - a1 !== 1) begin
      failures++; $display("FAIL b2b_rd1 got %h lat=%0d want %h lat=1", {er, rd}, r1 - a1, exp1);
    end
    checks++;
    if (a1 - a0 !== 3) begin
      failures++; $display("FAIL b2b_spacing got %0d want 3", a1 - a0);
    end
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp_ready(1'b0, 1'b0);
    set_rsp_ready(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_reset_mid_wait();
    test_latency();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_random();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory target for the next-generation multi-cycle and pipelined cores. It replaces the zero-wait, combinational-read data memory with a valid/ready request/response protocol that supports programmable wait states, byte-lane writes and an error response. The core initiates requests; this block is the responder. It accepts one request at a time and returns exactly one response per accepted request.

Parameters:
DEPTH, 256, number of 32-bit words stored; word index is addr[31:2].
LATENCY, 2, extra wait cycles between acceptance and the access; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  32  byte address.
req_wdata  input  32  write data.
req_be  input  4  byte-lane write enables; be[i] selects bits 8i+7:8i.
rsp_valid  output  1  response available.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  32  read data; 0 for writes and errors.
rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0. RAM contents are not reset.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready at a rising edge) captures we, addr, wdata and be into internal registers, loads counter=LATENCY, and moves to WAIT.
  - WAIT: req_ready=0. While counter!=0, decrement the counter each cycle. When counter==0, perform the access at that edge and move to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable. A handshake (rsp_valid & rsp_ready) returns the block to IDLE, clears rsp_valid, rsp_rdata and rsp_err, and sets req_ready=1 on the next cycle.
- Timing: for acceptance at edge k, rsp_valid rises after edge k+1+LATENCY. With LATENCY=0, the response appears 2 cycles after the request is presented. No same-cycle RESP->accept: the minimum spacing between accepted requests is LATENCY+3 cycles.
- Access rules at the WAIT->RESP edge:
  - Error when addr[1:0]!=0 or addr[31:2]>=DEPTH. In that case rsp_err=1, rsp_rdata=0, and RAM is unmodified.
  - Write: only lanes with be[i]=1 are updated; rsp_rdata=0, rsp_err=0. be=4'b0000 is a legal no-op write that still produces a response.
  - Read: rsp_rdata = the full stored word; be is ignored; rsp_err=0.
- Request capture: after acceptance, later changes on req_* inputs have no effect. req_valid asserted outside IDLE is ignored, not queued.
- Response stall: rsp_ready may stay low indefinitely; outputs are held.
- Reset mid-operation: the block returns to IDLE immediately and the pending transaction is dropped.
  - A write caught in WAIT is never performed.
  - A write that completed before reset remains in RAM.
- Address wrap: there is no wrap; every address above the range returns an error.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - BE_WORD=4'b1111, BE_HALF0=4'b0011, BE_HALF1=4'b1100.
  - Misalignment mask ADDR_ALIGN_MASK=2'b11.
- Sub-module dmem_bank:
  - Synchronous write, DEPTH x 32, per-byte write enables, combinational read.
  - Instantiated once.
  - The FSM, counter and error check stay in dmem_responder.

Test Plan:
1. Reset held low mid-WAIT of a write (addr 0x40, wdata 0xDEADBEEF, be 4'b1111) -> outputs return to reset values immediately. A later read of 0x40 returns the pre-reset contents, not 0xDEADBEEF.
2. LATENCY=2: write 0x00000019 to 0x64 with be 4'b1111 accepted at edge k -> rsp_valid rises after edge k+3 with rsp_err=0 and rsp_rdata=0. A read of 0x64 then returns 0x00000019.
3. Byte lanes: write 0x11223344 to 0x10 with be=1111, then write 0xAABBCCDD with be=0101 -> a read of 0x10 returns 0x11BB33DD.
4. Errors, DEPTH=256: read 0x400 -> rsp_err=1, rsp_rdata=0. Write 0x66 -> rsp_err=1, and a read of 0x64 is unchanged.
5. Response backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 and changing req_addr -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and no second access occurs. Releasing rsp_ready returns the block to IDLE with req_ready=1 one cycle later.
6. LATENCY=0 back-to-back reads of 0x0 and 0x4 with rsp_ready=1 -> each response arrives 2 cycles after its request, and successive acceptances are 3 cycles apart.
